// File: rtl/addr_sequencer_2b.sv
// addr_sequencer_2b: 2-bit address sweeper driving a 2-to-4 decoder select with dwell, one-shot/continuous modes
module addr_sequencer_2b (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       dir,
  input  logic       cont,
  input  logic [3:0] dwell,
  output logic       A0,
  output logic       A1,
  output logic       en,
  output logic       busy,
  output logic       done,
  output logic       wrap
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [1:0] addr;
  logic [3:0] dcnt;
  logic [1:0] scnt;
  logic       dir_l;
  logic       cont_l;
  logic [3:0] dwell_l;
  logic [1:0] nxt;
  logic       step;
  logic       wrap_step;
  assign A0 = addr[0];
  assign A1 = addr[1];
  // next address and wrap detection for a step in the latched direction
  always_comb begin
    nxt       = dir_l ? addr + 2'd1 : addr - 2'd1;
    wrap_step = dir_l ? (addr == 2'd3) : (addr == 2'd0);
    step      = (dcnt == dwell_l);
  end
  // sweep FSM: every output is a flop; stop beats a coincident step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= 2'd0;
      en      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
      dcnt    <= 4'd0;
      scnt    <= 2'd0;
      dir_l   <= 1'b0;
      cont_l  <= 1'b0;
      dwell_l <= 4'd0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            en      <= 1'b1;
            busy    <= 1'b1;
            dcnt    <= 4'd0;
            scnt    <= 2'd0;
            dir_l   <= dir;
            cont_l  <= cont;
            dwell_l <= dwell;
            addr    <= load ? load_val : addr;
          end else if (load) begin
            addr <= load_val;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            en    <= 1'b0;
            busy  <= 1'b0;
          end else if (step) begin
            dcnt <= 4'd0;
            if (!cont_l && scnt == 2'd3) begin
              state <= DONE;
              en    <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              addr <= nxt;
              scnt <= scnt + 2'd1;
              wrap <= wrap_step;
            end
          end else begin
            dcnt <= dcnt + 4'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
